// File: rtl/gpio_port_bank.sv
// NPORTS x 16-bit GPIO bank on the IOR_N/IOW_N strobe bus with its own ack FSM.
// Define GPIO_DEBOUNCE_EN to add a per-port input debouncer of DEB_CYCLES stable cycles.
module gpio_port_bank #(
  parameter int unsigned NPORTS     = 2,
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned ADR_W      = 5
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  input  logic [15:0]            wb_dat_i,
  output logic [15:0]            wb_dat_o,
  input  logic [ADR_W-1:0]       wb_adr_i,
  input  logic                   IOR_N,
  input  logic                   IOW_N,
  input  logic                   CS_N,
  output logic                   wb_ack_o,
  output logic                   irq_o,
  input  logic [NPORTS*16-1:0]   gpio_i,
  output logic [NPORTS*16-1:0]   gpio_o,
  output logic [NPORTS*16-1:0]   gpio_oe_o
);

  if (NPORTS < 1 || NPORTS > 8) begin : g_bad_nports
    $error("gpio_port_bank: NPORTS must be 1..8");
  end
  if ((64'd1 << ADR_W) <= 64'(NPORTS * 4)) begin : g_bad_adr_w
    $error("gpio_port_bank: ADR_W too small for NPORTS");
  end
  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("gpio_port_bank: DEB_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {StIdle, StAccess, StHold} state_e;

  state_e                r_state;
  logic                  r_op_wr;
  logic                  r_op_rd;
  logic                  r_ack;
  logic [15:0]           r_dat;
  logic                  r_irq;

  logic [15:0]           r_out  [NPORTS];
  logic [15:0]           r_dir  [NPORTS];
  logic [15:0]           r_stat [NPORTS];
  logic [NPORTS-1:0]     r_irqen;

  logic [NPORTS*16-1:0]  r_sync1;
  logic [NPORTS*16-1:0]  r_sync2;
  logic [NPORTS*16-1:0]  r_cond_d;

  logic [NPORTS*16-1:0]  w_cond;
  logic [NPORTS*16-1:0]  w_rise;
  logic [NPORTS-1:0]     w_stat_any;
  logic [15:0]           w_rd_data;
  logic                  w_wr_en;

  // Input conditioning: two-flop synchroniser, then optional debounce.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cond_d <= '0;
    end else begin
      r_sync1  <= gpio_i;
      r_sync2  <= r_sync1;
      r_cond_d <= w_cond;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0]      r_cnt [NPORTS];
  logic [NPORTS*16-1:0]  r_deb;

  // A pending change of sync (sync1 != sync2) restarts the stability count.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_deb <= '0;
      for (int p = 0; p < NPORTS; p++) r_cnt[p] <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (r_sync1[p*16 +: 16] != r_sync2[p*16 +: 16]) begin
          r_cnt[p] <= '0;
        end else if (r_sync2[p*16 +: 16] != r_deb[p*16 +: 16]) begin
          if (r_cnt[p] == DEB_MAX) begin
            r_deb[p*16 +: 16] <= r_sync2[p*16 +: 16];
            r_cnt[p]          <= '0;
          end else begin
            r_cnt[p] <= r_cnt[p] + 1'b1;
          end
        end else begin
          r_cnt[p] <= '0;
        end
      end
    end
  end

  assign w_cond = r_deb;
`else
  assign w_cond = r_sync2;
`endif

  assign w_rise  = w_cond & ~r_cond_d;
  assign w_wr_en = (r_state == StAccess) && r_op_wr;

  always_comb begin
    w_rd_data = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (wb_adr_i == ADR_W'(4 * p))     w_rd_data = r_out[p];
      if (wb_adr_i == ADR_W'(4 * p + 1)) w_rd_data = r_dir[p];
      if (wb_adr_i == ADR_W'(4 * p + 2)) w_rd_data = w_cond[p*16 +: 16];
      if (wb_adr_i == ADR_W'(4 * p + 3)) w_rd_data = r_stat[p];
    end
    if (wb_adr_i == ADR_W'(4 * NPORTS)) w_rd_data = 16'(r_irqen);
  end

  always_comb begin
    w_stat_any = '0;
    gpio_o     = '0;
    gpio_oe_o  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      w_stat_any[p]         = |r_stat[p];
      gpio_o[p*16 +: 16]    = r_out[p];
      gpio_oe_o[p*16 +: 16] = r_dir[p];
    end
  end

  // Access handshake: one operation per strobe assertion, ack held until release.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= StIdle;
      r_op_wr <= 1'b0;
      r_op_rd <= 1'b0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_ack <= 1'b0;
          if (!CS_N && (!IOR_N || !IOW_N)) begin
            r_state <= StAccess;
            r_op_wr <= !IOW_N;
            r_op_rd <= !IOR_N;
          end
        end
        StAccess: begin
          r_state <= StHold;
          r_ack   <= 1'b1;
          if (r_op_wr) begin
            if (r_op_rd) r_dat <= '0;
          end else if (r_op_rd) begin
            r_dat <= w_rd_data;
          end
        end
        StHold: begin
          if (CS_N || (IOR_N && IOW_N)) begin
            r_state <= StIdle;
            r_ack   <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // Register file; an edge set on the same cycle as a W1C wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_irqen <= '0;
      r_irq   <= 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
        r_out[p]  <= '0;
        r_dir[p]  <= '0;
        r_stat[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (w_wr_en && wb_adr_i == ADR_W'(4 * p))     r_out[p] <= wb_dat_i;
        if (w_wr_en && wb_adr_i == ADR_W'(4 * p + 1)) r_dir[p] <= wb_dat_i;
        if (w_wr_en && wb_adr_i == ADR_W'(4 * p + 3)) begin
          r_stat[p] <= (r_stat[p] & ~wb_dat_i) | w_rise[p*16 +: 16];
        end else begin
          r_stat[p] <= r_stat[p] | w_rise[p*16 +: 16];
        end
      end
      if (w_wr_en && wb_adr_i == ADR_W'(4 * NPORTS)) r_irqen <= wb_dat_i[NPORTS-1:0];
      r_irq <= |(r_irqen & w_stat_any);
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = r_irq;

endmodule

// File: tb/tb_gpio_port_bank.sv
// Self-checking bench for gpio_port_bank (NPORTS=2); read data checked via a scoreboard queue.
module tb_gpio_port_bank;

  localparam int NPORTS     = 2;
  localparam int ADR_W      = 5;
  localparam int DEB_CYCLES = 16;
`ifdef GPIO_DEBOUNCE_EN
  localparam int StatLat = 3 + DEB_CYCLES;
`else
  localparam int StatLat = 3;
`endif

  logic                  clk;
  logic                  rst_n;
  logic [15:0]           wb_dat_i;
  logic [15:0]           wb_dat_o;
  logic [ADR_W-1:0]      wb_adr_i;
  logic                  ior_n;
  logic                  iow_n;
  logic                  cs_n;
  logic                  wb_ack_o;
  logic                  irq_o;
  logic [NPORTS*16-1:0]  gpio_i;
  logic [NPORTS*16-1:0]  gpio_o;
  logic [NPORTS*16-1:0]  gpio_oe_o;

  gpio_port_bank #(
    .NPORTS     (NPORTS),
    .DEB_CYCLES (DEB_CYCLES),
    .ADR_W      (ADR_W)
  ) u_dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_adr_i   (wb_adr_i),
    .IOR_N      (ior_n),
    .IOW_N      (iow_n),
    .CS_N       (cs_n),
    .wb_ack_o   (wb_ack_o),
    .irq_o      (irq_o),
    .gpio_i     (gpio_i),
    .gpio_o     (gpio_o),
    .gpio_oe_o  (gpio_oe_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_acc(input bit rd, input bit wr, input logic [ADR_W-1:0] a,
                           input logic [15:0] d);
    wb_adr_i = a;
    wb_dat_i = d;
    cs_n     = 1'b0;
    ior_n    = !rd;
    iow_n    = !wr;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (wb_ack_o) break;
    end
  endtask

  task automatic release_acc(input string tag);
    cs_n  = 1'b1;
    ior_n = 1'b1;
    iow_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_ack_drop"}, 32'(wb_ack_o), 32'd0);
  endtask

  task automatic bus_write(input logic [ADR_W-1:0] a, input logic [15:0] d, input string tag);
    int lat;
    @(posedge clk);
    #1;
    drive_acc(1'b0, 1'b1, a, d);
    wait_ack(lat);
    check_eq({tag, "_ack_lat"}, 32'(lat), 32'd2);
    release_acc(tag);
  endtask

  task automatic bus_read(input logic [ADR_W-1:0] a, input logic [15:0] exp, input string tag);
    int lat;
    exp_q.push_back(32'(exp));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    drive_acc(1'b1, 1'b0, a, 16'h0000);
    wait_ack(lat);
    check_eq({tag, "_ack_lat"}, 32'(lat), 32'd2);
    check_eq(tag_q.pop_front(), 32'(wb_dat_o), exp_q.pop_front());
    release_acc(tag);
  endtask

  task automatic irq_timeline(input string tag);
    for (int c = 1; c <= StatLat + 1; c++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("%s_irq_c%0d", tag, c), 32'(irq_o), 32'(c == StatLat + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks;
    logic prev_ack;

    rst_n    = 1'b0;
    cs_n     = 1'b1;
    ior_n    = 1'b1;
    iow_n    = 1'b1;
    wb_adr_i = '0;
    wb_dat_i = '0;
    gpio_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_gpio_o", gpio_o, 32'h0);
    check_eq("rst_gpio_oe", gpio_oe_o, 32'h0);
    check_eq("rst_ack", 32'(wb_ack_o), 32'h0);
    check_eq("rst_irq", 32'(irq_o), 32'h0);
    check_eq("rst_dat", 32'(wb_dat_o), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write/read of port 1 registers and the unmapped space.
    bus_write(5'd4, 16'hA5C3, "wr_out1");
    bus_write(5'd5, 16'hFF00, "wr_dir1");
    check_eq("gpio_o_p1", gpio_o, 32'hA5C3_0000);
    check_eq("gpio_oe_p1", gpio_oe_o, 32'hFF00_0000);
    bus_read(5'd4, 16'hA5C3, "rd_out1");
    bus_read(5'd5, 16'hFF00, "rd_dir1");
    bus_write(5'd9, 16'hDEAD, "wr_unmapped");
    check_eq("dat_hold", 32'(wb_dat_o), 32'h0000_FF00);
    bus_read(5'd9, 16'h0000, "rd_unmapped");
    bus_read(5'd8, 16'h0000, "rd_irqen0");

    // Edge capture and interrupt timing on port 0 bit 3.
    bus_write(5'd8, 16'h0001, "wr_irqen1");
    @(posedge clk);
    #1;
    gpio_i[3] = 1'b1;
    irq_timeline("rise3");
    bus_read(5'd3, 16'h0008, "stat0_rise");
    bus_read(5'd2, 16'h0008, "in0_high");
    bus_write(5'd3, 16'h0008, "w1c");
    check_eq("irq_after_w1c", 32'(irq_o), 32'h0);
    bus_read(5'd3, 16'h0000, "stat0_clr");

    // W1C commit lands on the same edge as a new rise.
    @(posedge clk);
    #1;
    gpio_i[3] = 1'b0;
    repeat (StatLat + 2) @(posedge clk);
    #1;
    gpio_i[3] = 1'b1;
    repeat (StatLat - 2) @(posedge clk);
    #1;
    drive_acc(1'b0, 1'b1, 5'd3, 16'h0008);
    wait_ack(lat);
    check_eq("race_ack_lat", 32'(lat), 32'd2);
    release_acc("race");
    bus_read(5'd3, 16'h0008, "stat0_race");
    check_eq("irq_race", 32'(irq_o), 32'h1);
    bus_write(5'd3, 16'h0008, "w1c2");

    // Masked edge on port 1, then unmask.
    bus_write(5'd8, 16'h0000, "irqen_off");
    @(posedge clk);
    #1;
    gpio_i[21] = 1'b1;
    repeat (StatLat + 3) @(posedge clk);
    #1;
    check_eq("irq_masked", 32'(irq_o), 32'h0);
    bus_read(5'd7, 16'h0020, "stat1_rise");
    bus_read(5'd6, 16'h0020, "in1_high");
    bus_write(5'd8, 16'h0002, "irqen_p1");
    check_eq("irq_unmasked", 32'(irq_o), 32'h1);
    bus_read(5'd8, 16'h0002, "rd_irqen2");

    // Both strobes low: single write, read data forced to 0, one ack.
    @(posedge clk);
    #1;
    cs_n     = 1'b0;
    ior_n    = 1'b0;
    iow_n    = 1'b0;
    wb_adr_i = 5'd0;
    wb_dat_i = 16'h1234;
    acks     = 0;
    prev_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o && !prev_ack) acks++;
      prev_ack = wb_ack_o;
      if (i == 4) wb_dat_i = 16'hBEEF;
    end
    check_eq("conflict_acks", 32'(acks), 32'd1);
    check_eq("conflict_dat", 32'(wb_dat_o), 32'h0);
    check_eq("conflict_out0", 32'(gpio_o[15:0]), 32'h1234);
    release_acc("conflict");
    bus_read(5'd0, 16'h1234, "rd_out0");

    // Reset while in HOLD.
    @(posedge clk);
    #1;
    drive_acc(1'b1, 1'b0, 5'd4, 16'h0000);
    wait_ack(lat);
    check_eq("prerst_ack", 32'(wb_ack_o), 32'h1);
    #2;
    rst_n  = 1'b0;
    gpio_i = '0;
    #1;
    check_eq("midrst_ack", 32'(wb_ack_o), 32'h0);
    check_eq("midrst_gpio_o", gpio_o, 32'h0);
    check_eq("midrst_gpio_oe", gpio_oe_o, 32'h0);
    check_eq("midrst_irq", 32'(irq_o), 32'h0);
    cs_n  = 1'b1;
    ior_n = 1'b1;
    iow_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset while in ACCESS: the write must not land.
    @(posedge clk);
    #1;
    drive_acc(1'b0, 1'b1, 5'd1, 16'hFFFF);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    cs_n  = 1'b1;
    ior_n = 1'b1;
    iow_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("partial_oe", gpio_oe_o, 32'h0);
    bus_read(5'd1, 16'h0000, "dir0_after_rst");
    bus_read(5'd4, 16'h0000, "out1_after_rst");

`ifdef GPIO_DEBOUNCE_EN
    bus_write(5'd8, 16'h0001, "deb_irqen");
    @(posedge clk);
    #1;
    gpio_i[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    gpio_i[0] = 1'b0;
    repeat (30) @(posedge clk);
    bus_read(5'd2, 16'h0000, "deb_in0_glitch");
    bus_read(5'd3, 16'h0000, "deb_stat0_glitch");
    check_eq("deb_irq_glitch", 32'(irq_o), 32'h0);
    @(posedge clk);
    #1;
    gpio_i[0] = 1'b1;
    irq_timeline("deb_level");
    bus_read(5'd2, 16'h0001, "deb_in0_level");
    bus_read(5'd3, 16'h0001, "deb_stat0_level");
    repeat (20) @(posedge clk);
    #1;
    gpio_i[0] = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_port_bank.md
Name: gpio_port_bank

Overview:
- Parametrised general-purpose I/O controller and successor to the fixed LED/switch peripherals.
- Provides NPORTS bidirectional 16-bit ports, each with per-bit direction, input synchronisation, rising-edge capture and a maskable interrupt.
- Sits on the decoded I/O strobe bus (IOR_N/IOW_N plus chip-select) behind the address decoder.
- Generates its own acknowledge through a handshake FSM, so the system ACK generator only ORs it in.

Parameters:
- NPORTS, 2, number of 16-bit ports (1..8).
- DEB_CYCLES, 16, stable-input cycles required before the debounced value updates (used only when GPIO_DEBOUNCE_EN is defined; ≥2).
- ADR_W, 5, register word-address width; must satisfy 2^ADR_W > NPORTS*4.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data, registered
- wb_adr_i  in  ADR_W  register word address
- IOR_N  in  1  I/O read strobe, active low, level
- IOW_N  in  1  I/O write strobe, active low, level
- CS_N  in  1  chip select, active low
- wb_ack_o  out  1  access acknowledge
- irq_o  out  1  interrupt request, active high
- gpio_i  in  NPORTS*16  pin inputs, asynchronous
- gpio_o  out  NPORTS*16  output register values
- gpio_oe_o  out  NPORTS*16  per-bit output enable (1 = drive)

Behaviour:
- Reset (async assert, sync release): every register, synchroniser and FSM cleared; wb_dat_o=0, wb_ack_o=0, irq_o=0, gpio_o=0, gpio_oe_o=0.
- Register map, port p at base 4p:
  - +0 OUT: R/W.
  - +1 DIR: R/W.
  - +2 IN: RO, returns conditioned pin value.
  - +3 STAT: edge status, write-1-to-clear.
- Address NPORTS*4 is IRQEN: R/W, bits [NPORTS-1:0], upper bits read 0.
- All other addresses: read 0, writes ignored, still acknowledged.
- Access FSM states: IDLE, ACCESS, HOLD.
  - IDLE→ACCESS when CS_N=0 and (IOR_N=0 or IOW_N=0).
  - In ACCESS, exactly one operation is performed: a write commits the register, or a read loads wb_dat_o. Then →HOLD.
  - HOLD: wb_ack_o=1; stays until CS_N=1 or both strobes are high, then →IDLE with ack low the following cycle.
  - Ack therefore rises 2 cycles after the strobe is sampled low. Each strobe assertion performs exactly one access, never repeated.
  - IOR_N and IOW_N both low: write takes precedence and wb_dat_o is loaded with 0.
  - wb_dat_o holds its value outside reads.
- Input path: 2-flop synchroniser per bit, giving sync. Conditioned value cond = sync (debounce off) or deb (debounce on).
- Edge detection:
  - cond_d is cond delayed one cycle.
  - STAT[b] sets when cond[b]=1 and cond_d[b]=0.
  - A simultaneous set and W1C on the same bit leaves the bit set.
  - Latency without debounce: pin rise at cycle 0 gives STAT set visible at cycle 3.
  - Pins high at reset release produce STAT bits once synchronised; software clears them.
- irq_o is registered: irq_o <= OR over p of (IRQEN[p] & |STAT_p). It deasserts one cycle after the last enabled status bit clears.
- gpio_o = OUT registers and gpio_oe_o = DIR registers, concatenated with port 0 in the LSBs. IN reads cond regardless of DIR.
- Reset mid-access: FSM to IDLE, ack dropped immediately, partial write not committed.

Optional Feature:
- GPIO_DEBOUNCE_EN defined: one counter per port, width clog2(DEB_CYCLES).
  - While sync_p ≠ deb_p the counter increments; any change of sync_p during counting restarts it at 0.
  - When the counter reaches DEB_CYCLES-1, deb_p <= sync_p and the counter clears.
  - Pin-to-STAT latency = 3 + DEB_CYCLES cycles.
  - Glitches shorter than DEB_CYCLES cycles never reach IN or STAT.
- Not defined: no counters; cond = sync; DEB_CYCLES ignored.

Test Plan:
- Reset: assert wb_rst_n_i low mid-HOLD → wb_ack_o, gpio_o, gpio_oe_o, irq_o = 0 immediately; FSM returns to IDLE.
- Write/read with NPORTS=2:
  - Write OUT1 (addr 4) = 16'hA5C3 and DIR1 (addr 5) = 16'hFF00 → gpio_o[31:16]=A5C3, gpio_oe_o[31:16]=FF00.
  - Read back both values; ack rises 2 cycles after the strobe and clears 1 cycle after the strobe is released.
  - Read addr 9 (unmapped) → 0 with ack.
- Edge/IRQ, debounce off:
  - Set IRQEN=2'b01, raise gpio_i[3] → STAT0 = 0x0008 at cycle 3, irq_o = 1 at cycle 4.
  - W1C 0x0008 → irq_o = 0.
  - W1C in the same cycle as a new rise on bit 3 → bit stays set.
- Masking: edge on port 1 with IRQEN = 0 → STAT1 set, irq_o stays 0. Setting IRQEN bit 1 → irq_o rises within 2 cycles.
- Debounce on, DEB_CYCLES=16:
  - 10-cycle pulse on gpio_i[0] → IN0 and STAT0 unchanged.
  - 40-cycle high level → IN0 bit 0 = 1 and STAT0 bit 0 set at cycle 19.
- Strobe conflict: IOR_N and IOW_N both low writing 0x1234 to OUT0 → OUT0 = 0x1234, wb_dat_o = 0, a single ack, strobe held 10 cycles with only one commit.
